// File: rtl/alu_drv_pkg.sv
// Shared types and result widths for the ALU command driver.
package alu_drv_pkg;

   typedef enum logic [1:0] {
      UNIT_ARITH = 2'b00,
      UNIT_LOGIC = 2'b01,
      UNIT_CMP   = 2'b10,
      UNIT_SHIFT = 2'b11
   } alu_unit_e;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } drv_state_e;

   localparam int unsigned LOGIC_W = 16;
   localparam int unsigned CMP_W   = 4;
   localparam int unsigned SHIFT_W = 17;

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Request, ALU and response signals of the ALU command driver.
// master is the driver's view; slave is the command source / ALU side.
interface alu_cmd_driver_if import alu_drv_pkg::*; #(
   parameter int unsigned IN_WIDTH  = 16,
   parameter int unsigned OUT_WIDTH = 2 * IN_WIDTH
) ();

   logic                  REQ_VALID;
   logic                  REQ_READY;
   logic [IN_WIDTH-1:0]   REQ_A;
   logic [IN_WIDTH-1:0]   REQ_B;
   logic [3:0]            REQ_FUN;

   logic [IN_WIDTH-1:0]   ALU_A;
   logic [IN_WIDTH-1:0]   ALU_B;
   logic [3:0]            ALU_FUN;
   logic [OUT_WIDTH-1:0]  Arith_OUT;
   logic                  Carry_Out;
   logic [LOGIC_W-1:0]    logic_OUT;
   logic [CMP_W-1:0]      CMP_OUT;
   logic [SHIFT_W-1:0]    SHIFT_OUT;
   logic                  Arith_Flag;
   logic                  Logic_Flag;
   logic                  CMP_Flag;
   logic                  Shift_Flag;

   logic                  RSP_VALID;
   logic                  RSP_READY;
   logic [OUT_WIDTH-1:0]  RSP_DATA;
   logic                  RSP_CARRY;
   logic [1:0]            RSP_UNIT;
   logic                  RSP_ERR;

   modport master (
      input  REQ_VALID, REQ_A, REQ_B, REQ_FUN,
      input  Arith_OUT, Carry_Out, logic_OUT, CMP_OUT, SHIFT_OUT,
      input  Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
      input  RSP_READY,
      output REQ_READY, ALU_A, ALU_B, ALU_FUN,
      output RSP_VALID, RSP_DATA, RSP_CARRY, RSP_UNIT, RSP_ERR
   );

   modport slave (
      output REQ_VALID, REQ_A, REQ_B, REQ_FUN,
      output Arith_OUT, Carry_Out, logic_OUT, CMP_OUT, SHIFT_OUT,
      output Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
      output RSP_READY,
      input  REQ_READY, ALU_A, ALU_B, ALU_FUN,
      input  RSP_VALID, RSP_DATA, RSP_CARRY, RSP_UNIT, RSP_ERR
   );

endinterface

// File: rtl/alu_rsp_mux.sv
// Selects the addressed unit's flag and result, zero-extending the narrow units.
module alu_rsp_mux import alu_drv_pkg::*; #(
   parameter int unsigned OUT_WIDTH = 32
) (
   input  alu_unit_e             unit_i,
   input  logic [OUT_WIDTH-1:0]  arith_out_i,
   input  logic                  carry_out_i,
   input  logic [LOGIC_W-1:0]    logic_out_i,
   input  logic [CMP_W-1:0]      cmp_out_i,
   input  logic [SHIFT_W-1:0]    shift_out_i,
   input  logic                  arith_flag_i,
   input  logic                  logic_flag_i,
   input  logic                  cmp_flag_i,
   input  logic                  shift_flag_i,
   output logic                  flag_hit_o,
   output logic [OUT_WIDTH-1:0]  data_o,
   output logic                  carry_o
);

   always_comb begin
      flag_hit_o = 1'b0;
      data_o     = '0;
      carry_o    = 1'b0;
      unique case (unit_i)
         UNIT_ARITH: begin
            flag_hit_o = arith_flag_i;
            data_o     = arith_out_i;
            carry_o    = carry_out_i;
         end
         UNIT_LOGIC: begin
            flag_hit_o = logic_flag_i;
            data_o     = OUT_WIDTH'(logic_out_i);
         end
         UNIT_CMP: begin
            flag_hit_o = cmp_flag_i;
            data_o     = OUT_WIDTH'(cmp_out_i);
         end
         UNIT_SHIFT: begin
            flag_hit_o = shift_flag_i;
            data_o     = OUT_WIDTH'(shift_out_i);
         end
      endcase
   end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator front end for the 16-bit ALU: one request in flight, normalised response out.
// Optional WAIT timeout is built when ALU_DRV_TIMEOUT_EN is defined.
module alu_cmd_driver import alu_drv_pkg::*; #(
   parameter int unsigned IN_WIDTH    = 16,
   parameter int unsigned OUT_WIDTH   = 2 * IN_WIDTH
`ifdef ALU_DRV_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = 4
`endif
) (
   input  logic              CLK,
   input  logic              RST,
   alu_cmd_driver_if.master  bus
);

   drv_state_e            state_q, state_d;
   alu_unit_e             unit_q;
   logic [IN_WIDTH-1:0]   alu_a_q, alu_b_q;
   logic [3:0]            alu_fun_q;
   logic [OUT_WIDTH-1:0]  rsp_data_q, mux_data;
   logic                  rsp_carry_q, mux_carry, flag_hit;
   logic                  accept, capture, timeout, timeout_hit;

   alu_rsp_mux #(
      .OUT_WIDTH (OUT_WIDTH)
   ) u_rsp_mux (
      .unit_i       (unit_q),
      .arith_out_i  (bus.Arith_OUT),
      .carry_out_i  (bus.Carry_Out),
      .logic_out_i  (bus.logic_OUT),
      .cmp_out_i    (bus.CMP_OUT),
      .shift_out_i  (bus.SHIFT_OUT),
      .arith_flag_i (bus.Arith_Flag),
      .logic_flag_i (bus.Logic_Flag),
      .cmp_flag_i   (bus.CMP_Flag),
      .shift_flag_i (bus.Shift_Flag),
      .flag_hit_o   (flag_hit),
      .data_o       (mux_data),
      .carry_o      (mux_carry)
   );

   // ISSUE never looks at flags: they may still describe the previous operands.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      timeout = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.REQ_VALID) begin
               accept  = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (flag_hit) begin
               capture = 1'b1;
               state_d = StResp;
            end else if (timeout_hit) begin
               timeout = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            if (bus.RSP_READY) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_fun_q <= '0;
         unit_q    <= UNIT_ARITH;
      end else if (accept) begin
         alu_a_q   <= bus.REQ_A;
         alu_b_q   <= bus.REQ_B;
         alu_fun_q <= bus.REQ_FUN;
         unit_q    <= alu_unit_e'(bus.REQ_FUN[3:2]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rsp_data_q  <= '0;
         rsp_carry_q <= 1'b0;
      end else if (capture) begin
         rsp_data_q  <= mux_data;
         rsp_carry_q <= mux_carry;
      end else if (timeout) begin
         rsp_data_q  <= '0;
         rsp_carry_q <= 1'b0;
      end
   end

`ifdef ALU_DRV_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

   logic [CntW-1:0] cnt_q;
   logic            rsp_err_q;

   // Counter holds the number of completed WAIT cycles; a flag on the last one still wins.
   always_ff @(posedge CLK) begin
      if (RST || state_q == StIssue) cnt_q <= '0;
      else if (state_q == StWait)    cnt_q <= cnt_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST)          rsp_err_q <= 1'b0;
      else if (capture) rsp_err_q <= 1'b0;
      else if (timeout) rsp_err_q <= 1'b1;
   end

   assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYC - 1));
   assign bus.RSP_ERR = rsp_err_q;
`else
   assign timeout_hit = 1'b0;
   assign bus.RSP_ERR = 1'b0;
`endif

   assign bus.REQ_READY = (state_q == StIdle);
   assign bus.RSP_VALID = (state_q == StResp);
   assign bus.ALU_A     = alu_a_q;
   assign bus.ALU_B     = alu_b_q;
   assign bus.ALU_FUN   = alu_fun_q;
   assign bus.RSP_DATA  = rsp_data_q;
   assign bus.RSP_CARRY = rsp_carry_q;
   assign bus.RSP_UNIT  = unit_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural ALU flag stub.
// Timeout cases run only when ALU_DRV_TIMEOUT_EN is defined.
module tb_alu_cmd_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_cmd_driver_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) bus ();

   alu_cmd_driver #(
      .IN_WIDTH  (16),
      .OUT_WIDTH (32)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   // Stub: the addressed unit's flag rises flag_dly cycles after the ALU inputs were loaded.
   logic [3:0] age = 4'd15;
   int         flag_dly = 1;
   logic       kill = 1'b0;
   logic       logic_force = 1'b0;
   logic       fl_on;

   always @(posedge clk) begin
      if (bus.REQ_VALID && bus.REQ_READY) age <= 4'd0;
      else if (age != 4'd15)               age <= age + 4'd1;
   end

   assign fl_on          = !kill && (int'(age) >= flag_dly);
   assign bus.Arith_Flag = fl_on && bus.ALU_FUN[3:2] == 2'b00;
   assign bus.Logic_Flag = (fl_on && bus.ALU_FUN[3:2] == 2'b01) || logic_force;
   assign bus.CMP_Flag   = fl_on && bus.ALU_FUN[3:2] == 2'b10;
   assign bus.Shift_Flag = fl_on && bus.ALU_FUN[3:2] == 2'b11;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
      @(negedge clk);
      check_eq("req_ready_idle", bus.REQ_READY, 1'b1);
      bus.REQ_A     = a;
      bus.REQ_B     = b;
      bus.REQ_FUN   = fun;
      bus.REQ_VALID = 1'b1;
      @(posedge clk);
      #1;
      bus.REQ_VALID = 1'b0;
      check_eq("alu_a", bus.ALU_A, a);
      check_eq("alu_b", bus.ALU_B, b);
      check_eq("alu_fun", bus.ALU_FUN, fun);
      check_eq("req_ready_busy", bus.REQ_READY, 1'b0);
   endtask

   // Samples #1 after each edge; lat counts edges after the accept edge.
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!bus.RSP_VALID && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic ack_rsp;
      @(negedge clk);
      bus.RSP_READY = 1'b1;
      @(posedge clk);
      #1;
      bus.RSP_READY = 1'b0;
      check_eq("rsp_valid_after_ack", bus.RSP_VALID, 1'b0);
      check_eq("req_ready_after_ack", bus.REQ_READY, 1'b1);
   endtask

   task automatic run_op(input string tag, input logic [3:0] fun, input int exp_lat,
                         input logic [31:0] exp_data, input logic exp_carry, input logic exp_err);
      int lat;
      issue(16'h1111, 16'h2222, fun);
      wait_rsp(lat);
      check_eq({tag, "_lat"}, lat, exp_lat);
      check_eq({tag, "_data"}, bus.RSP_DATA, exp_data);
      check_eq({tag, "_carry"}, bus.RSP_CARRY, exp_carry);
      check_eq({tag, "_unit"}, bus.RSP_UNIT, fun[3:2]);
      check_eq({tag, "_err"}, bus.RSP_ERR, exp_err);
      ack_rsp();
   endtask

   initial begin
      int lat;
      bus.REQ_VALID = 1'b0;
      bus.REQ_A     = '0;
      bus.REQ_B     = '0;
      bus.REQ_FUN   = '0;
      bus.RSP_READY = 1'b0;
      bus.Arith_OUT = 32'h0000_8000;
      bus.Carry_Out = 1'b1;
      bus.logic_OUT = 16'hA5C3;
      bus.CMP_OUT   = 4'hF;
      bus.SHIFT_OUT = 17'h1FFFF;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_eq("rst_req_ready", bus.REQ_READY, 1'b1);
      check_eq("rst_rsp_valid", bus.RSP_VALID, 1'b0);
      check_eq("rst_alu_fun", bus.ALU_FUN, 4'h0);
      check_eq("rst_alu_a", bus.ALU_A, 16'h0);
      check_eq("rst_rsp_data", bus.RSP_DATA, 32'h0);
      check_eq("rst_rsp_err", bus.RSP_ERR, 1'b0);

      // Arith with carry
      issue(16'h7FFF, 16'h0001, 4'b0000);
      wait_rsp(lat);
      check_eq("arith_lat", lat, 2);
      check_eq("arith_data", bus.RSP_DATA, 32'h0000_8000);
      check_eq("arith_carry", bus.RSP_CARRY, 1'b1);
      check_eq("arith_unit", bus.RSP_UNIT, 2'd0);
      check_eq("arith_err", bus.RSP_ERR, 1'b0);
      ack_rsp();

      // Zero-extension; Carry_Out stays 1 but must not leak into non-arith responses
      run_op("cmp", 4'b1001, 2, 32'h0000_000F, 1'b0, 1'b0);
      run_op("shift", 4'b1100, 2, 32'h0001_FFFF, 1'b0, 1'b0);

      // Flag already high during ISSUE must still be ignored there
      flag_dly = 0;
      run_op("logic_early", 4'b0101, 2, 32'h0000_A5C3, 1'b0, 1'b0);
      flag_dly = 1;

      // Foreign flag held high, own flag delayed 3 cycles
      logic_force  = 1'b1;
      flag_dly     = 3;
      bus.CMP_OUT  = 4'h6;
      run_op("stale", 4'b1000, 4, 32'h0000_0006, 1'b0, 1'b0);
      logic_force  = 1'b0;
      flag_dly     = 1;

      // Backpressure
      bus.Arith_OUT = 32'h1234_5678;
      bus.Carry_Out = 1'b0;
      issue(16'h0102, 16'h0304, 4'b0001);
      wait_rsp(lat);
      check_eq("bp_lat", lat, 2);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         bus.Arith_OUT = 32'hDEAD_0000 + 32'(i);
         check_eq("bp_valid", bus.RSP_VALID, 1'b1);
         check_eq("bp_data", bus.RSP_DATA, 32'h1234_5678);
         check_eq("bp_carry", bus.RSP_CARRY, 1'b0);
         check_eq("bp_req_ready", bus.REQ_READY, 1'b0);
      end
      ack_rsp();

`ifdef ALU_DRV_TIMEOUT_EN
      kill = 1'b1;
      bus.logic_OUT = 16'h7777;
      run_op("timeout", 4'b0100, 5, 32'h0, 1'b0, 1'b1);
      kill = 1'b0;
      // Flag on the cycle the count reaches the limit wins
      flag_dly = 4;
      run_op("late_flag", 4'b0100, 5, 32'h0000_7777, 1'b0, 1'b0);
      flag_dly = 1;
`endif

      // Reset mid-WAIT
      kill = 1'b1;
      issue(16'h00AA, 16'h0055, 4'b0110);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      kill = 1'b0;
      check_eq("rstw_rsp_valid", bus.RSP_VALID, 1'b0);
      check_eq("rstw_alu_fun", bus.ALU_FUN, 4'h0);
      check_eq("rstw_req_ready", bus.REQ_READY, 1'b1);
      check_eq("rstw_rsp_err", bus.RSP_ERR, 1'b0);
      bus.Arith_OUT = 32'hFFFF_0001;
      bus.Carry_Out = 1'b1;
      run_op("post_rst", 4'b0010, 2, 32'hFFFF_0001, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
